fc_result_axis_tx: RTL and testbench

- Output-side AXI4-Stream master of the CNN inference core; counterpart to the 8-bit `s_axis` image input.
- Captures one parallel vector of signed 16-bit fully-connected layer results in a single cycle.
- Serializes the vector as little-endian bytes on `m_axis`, marks the final byte with `m_axis_last`, and pulses `o_intr` when the frame has been fully accepted.
- Sits between the final FC layer and the host DMA.

---
 rtl/fc_result_axis_tx.sv | 158 +++++++++++++++
 tb/tb_fc_result_axis_tx.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_result_axis_tx.sv
// Purpose: captures one vector of NUM_OUT signed 16-bit FC results and streams it as little-endian bytes on m_axis, last on final byte, o_intr on completion.
// Latency: first byte valid the cycle after capture; 2*NUM_OUT bytes (+1 trailer), then one DONE cycle with o_intr.
// Backpressure: m_axis_valid/ready; data/last hold while stalled; i_valid while busy is dropped. Optional argmax trailer: FC_RESULT_ARGMAX_EN.
module fc_result_axis_tx #(
  parameter int NUM_OUT = 16,
  parameter int DATA_W  = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_valid,
  input  logic [NUM_OUT*DATA_W-1:0]   i_data,
  output logic                        o_busy,
  output logic [7:0]                  m_axis_data,
  output logic                        m_axis_valid,
  input  logic                        m_axis_ready,
  output logic                        m_axis_last,
  output logic                        o_intr
);

  localparam int NB    = 2 * NUM_OUT;
  localparam int CNT_W = $clog2(NB);
  localparam int WI_W  = CNT_W - 1;
  localparam logic [CNT_W-1:0] LAST_B = CNT_W'(NB - 1);

`ifdef FC_RESULT_ARGMAX_EN
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEND    = 2'd1,
    S_DONE    = 2'd2,
    S_TRAILER = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;
`endif

  state_t                      state_q;
  state_t                      state_d;
  logic [NUM_OUT*DATA_W-1:0]   frame_q;
  logic [CNT_W-1:0]            b_q;
  logic [WI_W-1:0]             word_idx;
  logic [DATA_W-1:0]           cur_word;
  logic [7:0]                  cur_byte;
  logic                        capture;
  logic                        send_hs;

  assign word_idx = b_q[CNT_W-1:1];
  assign send_hs  = (state_q == S_SEND) && m_axis_ready;

  // Select the word addressed by the byte counter from the frame buffer.
  always_comb begin
    cur_word = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (word_idx == WI_W'(k)) cur_word = frame_q[k*DATA_W +: DATA_W];
    end
  end

  // Even byte counts carry the low byte, odd counts the high byte.
  always_comb begin
    cur_byte = b_q[0] ? cur_word[15:8] : cur_word[7:0];
  end

`ifdef FC_RESULT_ARGMAX_EN
  logic signed [DATA_W-1:0] max_q;
  logic [7:0]               idx_q;

  // Running signed max, updated on each high-byte handshake; strict compare keeps the lowest index on ties.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      max_q <= '0;
      idx_q <= '0;
    end else if (capture) begin
      max_q <= '0;
      idx_q <= '0;
    end else if (send_hs && b_q[0]) begin
      if ((word_idx == '0) || ($signed(cur_word) > max_q)) begin
        max_q <= $signed(cur_word);
        idx_q <= 8'(word_idx);
      end
    end
  end
`endif

  // State register; reset abandons any partial frame.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake outputs; valid depends only on state, never on ready.
  always_comb begin
    state_d      = state_q;
    capture      = 1'b0;
    m_axis_valid = 1'b0;
    m_axis_last  = 1'b0;
    o_intr       = 1'b0;
    o_busy       = 1'b1;
    case (state_q)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_valid) begin
          capture = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        m_axis_valid = 1'b1;
`ifdef FC_RESULT_ARGMAX_EN
        if (m_axis_ready && (b_q == LAST_B)) state_d = S_TRAILER;
`else
        m_axis_last = (b_q == LAST_B);
        if (m_axis_ready && (b_q == LAST_B)) state_d = S_DONE;
`endif
      end
`ifdef FC_RESULT_ARGMAX_EN
      S_TRAILER: begin
        m_axis_valid = 1'b1;
        m_axis_last  = 1'b1;
        if (m_axis_ready) state_d = S_DONE;
      end
`endif
      S_DONE: begin
        o_intr  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        o_busy  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Output byte mux; driven to zero whenever no byte is offered.
  always_comb begin
    m_axis_data = 8'h00;
    if (state_q == S_SEND) m_axis_data = cur_byte;
`ifdef FC_RESULT_ARGMAX_EN
    if (state_q == S_TRAILER) m_axis_data = idx_q;
`endif
  end

  // Frame buffer capture and byte counter; the counter only moves on a handshake.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      frame_q <= '0;
      b_q     <= '0;
    end else if (capture) begin
      frame_q <= i_data;
      b_q     <= '0;
    end else if (send_hs) begin
      b_q <= b_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fc_result_axis_tx.sv
// Bench for fc_result_axis_tx: randomized frames and ready patterns checked against a byte-list model.
// Model expands each word into low/high bytes and appends the argmax index when the trailer is built in.
// Each scenario task does its own comparisons; one summary line at the end.
module tb_fc_result_axis_tx;
  localparam int N    = 16;
  localparam int W    = 16;
  localparam int VW   = N * W;
  localparam int MAXC = 4000;
`ifdef FC_RESULT_ARGMAX_EN
  localparam int TRL = 1;
`else
  localparam int TRL = 0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_valid;
  logic [VW-1:0] i_data;
  logic          o_busy;
  logic [7:0]    m_axis_data;
  logic          m_axis_valid;
  logic          m_axis_ready;
  logic          m_axis_last;
  logic          o_intr;

  fc_result_axis_tx #(.NUM_OUT(N), .DATA_W(W)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .o_busy       (o_busy),
    .m_axis_data  (m_axis_data),
    .m_axis_valid (m_axis_valid),
    .m_axis_ready (m_axis_ready),
    .m_axis_last  (m_axis_last),
    .o_intr       (o_intr)
  );

  always #5 i_clk = ~i_clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_bytes[$];
  logic [7:0] got_bytes[$];
  logic       got_last[$];
  int         stab_bad, vdrop, busy_bad, intr_cyc, last_hs_cyc;
  logic       timed_out, intr_vld;

  // Reference: words in index order, low byte first; trailer is the first index holding the max.
  function automatic void build_expected(input logic [VW-1:0] v);
    logic signed [W-1:0] w;
    logic signed [W-1:0] best;
    int bi;
    exp_bytes.delete();
    best = v[W-1:0];
    bi = 0;
    for (int k = 0; k < N; k++) begin
      w = v[k*W +: W];
      exp_bytes.push_back(w[7:0]);
      exp_bytes.push_back(w[15:8]);
      if (w > best) begin
        best = w;
        bi = k;
      end
    end
    if (TRL == 1) exp_bytes.push_back(8'(bi));
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int k = 0; k < VW / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic ready_for(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return ((cyc % 4) == 0) || ((cyc % 4) == 3);
      2:       return $urandom_range(0, 2) != 0;
      default: return $urandom_range(0, 3) == 0;
    endcase
  endfunction

  // Pulses i_valid now (caller sits just after a rising edge), then collects bytes until o_intr.
  task automatic run_frame(input logic [VW-1:0] vec, input int mode, input int inj_cyc, input logic [VW-1:0] inj_vec);
    logic       prev_stall;
    logic [7:0] prev_d;
    logic       prev_l;
    got_bytes.delete();
    got_last.delete();
    stab_bad = 0; vdrop = 0; busy_bad = 0;
    intr_cyc = -1; last_hs_cyc = -1; timed_out = 1'b1; intr_vld = 1'b0;
    prev_stall = 1'b0; prev_d = 8'h00; prev_l = 1'b0;
    i_valid = 1'b1;
    i_data  = vec;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_data  = ~vec;
    for (int cyc = 0; cyc < MAXC; cyc++) begin
      m_axis_ready = ready_for(mode, cyc);
      if (cyc == inj_cyc) begin
        i_valid = 1'b1;
        i_data  = inj_vec;
      end
      @(negedge i_clk);
      if (prev_stall && (m_axis_valid !== 1'b1 || m_axis_data !== prev_d || m_axis_last !== prev_l)) stab_bad++;
      if (o_busy !== 1'b1) busy_bad++;
      if (o_intr === 1'b1) begin
        intr_cyc  = cyc;
        intr_vld  = m_axis_valid;
        timed_out = 1'b0;
        break;
      end
      if (m_axis_valid !== 1'b1) vdrop++;
      if (m_axis_valid === 1'b1 && m_axis_ready === 1'b1) begin
        got_bytes.push_back(m_axis_data);
        got_last.push_back(m_axis_last);
        last_hs_cyc = cyc;
      end
      prev_stall = (m_axis_valid === 1'b1) && (m_axis_ready !== 1'b1);
      prev_d = m_axis_data;
      prev_l = m_axis_last;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
    end
    i_valid = 1'b0;
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b0; i_valid = 1'b0; i_data = '0; m_axis_ready = 1'b0;
    #12;
    n_cmp++; if (m_axis_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", m_axis_valid); end
    n_cmp++; if (m_axis_data !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h exp 00", m_axis_data); end
    n_cmp++; if (m_axis_last !== 1'b0) begin n_bad++; $display("FAIL reset_last got %b exp 0", m_axis_last); end
    n_cmp++; if (o_intr !== 1'b0) begin n_bad++; $display("FAIL reset_intr got %b exp 0", o_intr); end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", o_busy); end
    @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
  endtask

  task automatic test_word_order();
    logic [VW-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = 16'h0100 + 16'(k);
    build_expected(v);
    run_frame(v, 0, -1, '0);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL wo_timeout no o_intr within %0d cycles", MAXC); end
    n_cmp++; if (got_bytes.size() != exp_bytes.size()) begin n_bad++; $display("FAIL wo_len got %0d exp %0d", got_bytes.size(), exp_bytes.size()); end
    for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++) begin
      n_cmp++; if (got_bytes[i] !== exp_bytes[i]) begin n_bad++; $display("FAIL wo_byte[%0d] got %h exp %h", i, got_bytes[i], exp_bytes[i]); end
      n_cmp++; if (got_last[i] !== (i == exp_bytes.size() - 1)) begin n_bad++; $display("FAIL wo_last[%0d] got %b", i, got_last[i]); end
    end
    n_cmp++; if (intr_cyc !== 2 * N + TRL) begin n_bad++; $display("FAIL wo_intr_cycle got %0d exp %0d", intr_cyc, 2 * N + TRL); end
    n_cmp++; if (intr_vld !== 1'b0) begin n_bad++; $display("FAIL wo_valid_in_done got %b exp 0", intr_vld); end
    n_cmp++; if (busy_bad !== 0) begin n_bad++; $display("FAIL wo_busy low cycles %0d exp 0", busy_bad); end
    n_cmp++; if (o_intr !== 1'b0 || o_busy !== 1'b0) begin n_bad++; $display("FAIL wo_idle_after intr %b busy %b exp 0 0", o_intr, o_busy); end
  endtask

  task automatic test_backpressure();
    logic [VW-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = 16'(0 - k);
    build_expected(v);
    run_frame(v, 1, -1, '0);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL bp_timeout no o_intr within %0d cycles", MAXC); end
    n_cmp++; if (got_bytes.size() != exp_bytes.size()) begin n_bad++; $display("FAIL bp_len got %0d exp %0d", got_bytes.size(), exp_bytes.size()); end
    for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++) begin
      n_cmp++; if (got_bytes[i] !== exp_bytes[i]) begin n_bad++; $display("FAIL bp_byte[%0d] got %h exp %h", i, got_bytes[i], exp_bytes[i]); end
      n_cmp++; if (got_last[i] !== (i == exp_bytes.size() - 1)) begin n_bad++; $display("FAIL bp_last[%0d] got %b", i, got_last[i]); end
    end
    n_cmp++; if (stab_bad !== 0) begin n_bad++; $display("FAIL bp_stall_stability unstable cycles %0d exp 0", stab_bad); end
    n_cmp++; if (vdrop !== 0) begin n_bad++; $display("FAIL bp_valid_drop cycles %0d exp 0", vdrop); end
    n_cmp++; if (intr_cyc !== last_hs_cyc + 1) begin n_bad++; $display("FAIL bp_intr_timing got %0d exp %0d", intr_cyc, last_hs_cyc + 1); end
  endtask

  task automatic test_argmax();
    logic [VW-1:0] v;
    v = '0;
    v[0*W +: W] = 16'(-5);
    v[1*W +: W] = 16'd3;
    v[2*W +: W] = 16'd7;
    v[3*W +: W] = 16'(-100);
    v[4*W +: W] = 16'd7;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        for (int k = 0; k < N; k++) v[k*W +: W] = 16'(-(k + 2));
        v[9*W +: W] = 16'hFFFF;
      end
      build_expected(v);
      run_frame(v, 2, -1, '0);
      n_cmp++; if (timed_out) begin n_bad++; $display("FAIL am_timeout pass %0d", pass); end
      n_cmp++; if (got_bytes.size() != exp_bytes.size()) begin n_bad++; $display("FAIL am_len got %0d exp %0d", got_bytes.size(), exp_bytes.size()); end
      for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++) begin
        n_cmp++; if (got_bytes[i] !== exp_bytes[i]) begin n_bad++; $display("FAIL am_byte[%0d] got %h exp %h", i, got_bytes[i], exp_bytes[i]); end
        n_cmp++; if (got_last[i] !== (i == exp_bytes.size() - 1)) begin n_bad++; $display("FAIL am_last[%0d] got %b", i, got_last[i]); end
      end
`ifdef FC_RESULT_ARGMAX_EN
      n_cmp++;
      if (got_bytes.size() != 33 || got_bytes[got_bytes.size() - 1] !== ((pass == 0) ? 8'h02 : 8'h09)) begin
        n_bad++; $display("FAIL am_trailer pass %0d got size %0d", pass, got_bytes.size());
      end
`else
      n_cmp++; if (got_bytes.size() != 32) begin n_bad++; $display("FAIL am_no_trailer got %0d bytes exp 32", got_bytes.size()); end
`endif
    end
  endtask

  task automatic test_busy_drop();
    logic [VW-1:0] va, vb, vc;
    va = rand_vec(); vb = rand_vec(); vc = rand_vec();
    build_expected(va);
    run_frame(va, 0, 3, vb);
    n_cmp++; if (got_bytes.size() != exp_bytes.size()) begin n_bad++; $display("FAIL bd_len got %0d exp %0d", got_bytes.size(), exp_bytes.size()); end
    for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++) begin
      n_cmp++; if (got_bytes[i] !== exp_bytes[i]) begin n_bad++; $display("FAIL bd_byte[%0d] got %h exp %h", i, got_bytes[i], exp_bytes[i]); end
    end
    n_cmp++; if (intr_cyc !== 2 * N + TRL) begin n_bad++; $display("FAIL bd_intr_cycle got %0d exp %0d", intr_cyc, 2 * N + TRL); end
    build_expected(vc);
    run_frame(vc, 0, -1, '0);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL bd_third_timeout frame right after DONE not started"); end
    n_cmp++; if (got_bytes.size() != exp_bytes.size()) begin n_bad++; $display("FAIL bd_third_len got %0d exp %0d", got_bytes.size(), exp_bytes.size()); end
    for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++) begin
      n_cmp++; if (got_bytes[i] !== exp_bytes[i]) begin n_bad++; $display("FAIL bd_third_byte[%0d] got %h exp %h", i, got_bytes[i], exp_bytes[i]); end
    end
  endtask

  task automatic test_async_reset();
    logic [VW-1:0] v;
    int intr_seen;
    v = rand_vec();
    build_expected(v);
    intr_seen = 0;
    i_valid = 1'b1; i_data = v;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    m_axis_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge i_clk); #1;
    end
    m_axis_ready = 1'b0;
    @(negedge i_clk);
    n_cmp++; if (m_axis_valid !== 1'b1 || m_axis_data !== exp_bytes[10]) begin n_bad++; $display("FAIL ar_byte10 valid %b data %h exp 1 %h", m_axis_valid, m_axis_data, exp_bytes[10]); end
    #2;
    i_rst = 1'b0;
    #1;
    n_cmp++; if (m_axis_valid !== 1'b0) begin n_bad++; $display("FAIL ar_valid_async got %b exp 0", m_axis_valid); end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL ar_busy_async got %b exp 0", o_busy); end
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      if (o_intr !== 1'b0) intr_seen++;
    end
    #1;
    i_rst = 1'b1;
    m_axis_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge i_clk);
      if (o_intr !== 1'b0 || m_axis_valid !== 1'b0) intr_seen++;
    end
    n_cmp++; if (intr_seen !== 0) begin n_bad++; $display("FAIL ar_no_intr_no_resume bad cycles %0d exp 0", intr_seen); end
    @(posedge i_clk); #1;
    v = rand_vec();
    build_expected(v);
    run_frame(v, 2, -1, '0);
    n_cmp++; if (got_bytes.size() != exp_bytes.size()) begin n_bad++; $display("FAIL ar_fresh_len got %0d exp %0d", got_bytes.size(), exp_bytes.size()); end
    for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++) begin
      n_cmp++; if (got_bytes[i] !== exp_bytes[i]) begin n_bad++; $display("FAIL ar_fresh_byte[%0d] got %h exp %h", i, got_bytes[i], exp_bytes[i]); end
    end
  endtask

  task automatic test_random();
    logic [VW-1:0] v;
    for (int f = 0; f < 6; f++) begin
      v = rand_vec();
      build_expected(v);
      run_frame(v, 2 + (f % 2), -1, '0);
      n_cmp++; if (timed_out) begin n_bad++; $display("FAIL rnd_timeout frame %0d", f); end
      n_cmp++; if (got_bytes.size() != exp_bytes.size()) begin n_bad++; $display("FAIL rnd_len frame %0d got %0d exp %0d", f, got_bytes.size(), exp_bytes.size()); end
      for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++) begin
        n_cmp++; if (got_bytes[i] !== exp_bytes[i]) begin n_bad++; $display("FAIL rnd_byte f%0d[%0d] got %h exp %h", f, i, got_bytes[i], exp_bytes[i]); end
        n_cmp++; if (got_last[i] !== (i == exp_bytes.size() - 1)) begin n_bad++; $display("FAIL rnd_last f%0d[%0d] got %b", f, i, got_last[i]); end
      end
      n_cmp++; if (stab_bad !== 0 || vdrop !== 0) begin n_bad++; $display("FAIL rnd_flow frame %0d unstable %0d drops %0d exp 0 0", f, stab_bad, vdrop); end
      n_cmp++; if (intr_cyc !== last_hs_cyc + 1 || intr_vld !== 1'b0) begin n_bad++; $display("FAIL rnd_intr frame %0d got cyc %0d valid %b exp %0d 0", f, intr_cyc, intr_vld, last_hs_cyc + 1); end
      // idle gap of random length between frames
      for (int g = 0; g < $urandom_range(0, 3); g++) begin
        @(posedge i_clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_order();
    test_backpressure();
    test_argmax();
    test_busy_drop();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
